// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : FSM state encoding and width helpers for the FFT stage sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int stg_w(input int log2n);
    return ($clog2(log2n) < 1) ? 1 : $clog2(log2n);
  endfunction

  function automatic int cnt_w(input int log2n);
    return log2n - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_addr_gen.sv
// ============================================================================
// fft_addr_gen : maps butterfly index k and stage s to the in-place DIT
// address pair and twiddle index. Purely combinational.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 3
) (
  input  logic [cnt_w(LOG2N)-1:0] k,
  input  logic [stg_w(LOG2N)-1:0] stage,
  output logic [LOG2N-1:0]        addr_a,
  output logic [LOG2N-1:0]        addr_b,
  output logic [cnt_w(LOG2N)-1:0] tw_idx
);

  localparam int CNT_W = cnt_w(LOG2N);

  logic [LOG2N-1:0] kx;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;

  always_comb begin
    kx     = LOG2N'(k);
    span   = LOG2N'(1) << stage;
    pos    = kx & (span - LOG2N'(1));
    grp    = kx >> stage;
    // grp < 2^(LOG2N-1-s), so shifting by s+1 never loses bits
    addr_a = (grp << (int'(stage) + 1)) | pos;
    addr_b = addr_a | span;
    tw_idx = CNT_W'(pos << (LOG2N - 1 - int'(stage)));
  end

endmodule

`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
// ============================================================================
// fft_stage_sequencer : steps LOG2N radix-2 stages, issuing N/2 butterflies per
// stage, draining the butterfly pipeline and flipping the ping-pong bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N      = 3,
  parameter int BF_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    bf_ready,
  output logic                    bf_valid,
  output logic [LOG2N-1:0]        bf_addr_a,
  output logic [LOG2N-1:0]        bf_addr_b,
  output logic [cnt_w(LOG2N)-1:0] tw_idx,
  output logic [stg_w(LOG2N)-1:0] stage,
  output logic                    bank_sel,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = cnt_w(LOG2N);
  localparam int STG_W = stg_w(LOG2N);
  localparam int DW    = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  localparam logic [CNT_W-1:0] K_LAST   = '1;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2N - 1);
  localparam logic [DW-1:0]    D_LAST   = DW'(BF_LATENCY - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  k, k_nxt;
  logic [DW-1:0]     dcnt, dcnt_nxt;
  logic [STG_W-1:0]  stage_nxt;
  logic              bank_nxt;
  logic [LOG2N-1:0]  gen_a, gen_b;
  logic [CNT_W-1:0]  gen_tw;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    dcnt_nxt  = dcnt;
    stage_nxt = stage;
    bank_nxt  = bank_sel;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (bf_ready) begin
          if (k == K_LAST) begin
            state_nxt = S_DRAIN;
            dcnt_nxt  = '0;
          end else begin
            k_nxt = k + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (dcnt == D_LAST) begin
          dcnt_nxt = '0;
          k_nxt    = '0;
          if (stage == STG_LAST) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ISSUE;
            stage_nxt = stage + STG_W'(1);
            bank_nxt  = ~bank_sel;
          end
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        stage_nxt = '0;
        bank_nxt  = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Addresses are generated from next-cycle k/stage so they register alongside bf_valid
  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .k      (k_nxt),
    .stage  (stage_nxt),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      dcnt      <= '0;
      stage     <= '0;
      bank_sel  <= 1'b0;
      bf_valid  <= 1'b0;
      bf_addr_a <= '0;
      bf_addr_b <= '0;
      tw_idx    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      dcnt      <= dcnt_nxt;
      stage     <= stage_nxt;
      bank_sel  <= bank_nxt;
      bf_valid  <= (state_nxt == S_ISSUE);
      bf_addr_a <= (state_nxt == S_ISSUE) ? gen_a  : '0;
      bf_addr_b <= (state_nxt == S_ISSUE) ? gen_b  : '0;
      tw_idx    <= (state_nxt == S_ISSUE) ? gen_tw : '0;
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
    end
  end

endmodule

`default_nettype wire
